// File: rtl/counter_b4_sched_if.sv
// rtl/counter_b4_sched_if.sv - requester and counter-side signal bundle for counter_b4_sched
//
// master : the scheduler (drives grants, results and the counter controls)
// slave  : the requesters plus the shared counter (drive jobs, Q and rco)
//
// Signals:
//   sq_req[2]                job request, level-sensitive, one bit per requester
//   sq_mode0/1[2]            job counting mode
//   sq_seed0/1[4]            job start value
//   sq_len0/1[4]             RUN cycles (0 = load-only)
//   sq_gnt[2]                one-hot grant held for the whole job
//   sq_done[2]               one-cycle completion pulse
//   sq_result[4]             final count of the last job
//   sq_rco_cnt[4]            rco-high RUN cycles of the last job, saturating
//   sq_busy                  high outside IDLE
//   sq_cnt_enable/mode/D     counter controls
//   sq_cnt_Q[4], sq_cnt_rco  counter outputs
interface counter_b4_sched_if;
    logic [1:0] sq_req;
    logic [1:0] sq_mode0;
    logic [1:0] sq_mode1;
    logic [3:0] sq_seed0;
    logic [3:0] sq_seed1;
    logic [3:0] sq_len0;
    logic [3:0] sq_len1;
    logic [1:0] sq_gnt;
    logic [1:0] sq_done;
    logic [3:0] sq_result;
    logic [3:0] sq_rco_cnt;
    logic       sq_busy;
    logic       sq_cnt_enable;
    logic [1:0] sq_cnt_mode;
    logic [3:0] sq_cnt_D;
    logic [3:0] sq_cnt_Q;
    logic       sq_cnt_rco;

    modport master (
        input  sq_req, sq_mode0, sq_mode1, sq_seed0, sq_seed1, sq_len0, sq_len1,
        input  sq_cnt_Q, sq_cnt_rco,
        output sq_gnt, sq_done, sq_result, sq_rco_cnt, sq_busy,
        output sq_cnt_enable, sq_cnt_mode, sq_cnt_D
    );

    modport slave (
        output sq_req, sq_mode0, sq_mode1, sq_seed0, sq_seed1, sq_len0, sq_len1,
        output sq_cnt_Q, sq_cnt_rco,
        input  sq_gnt, sq_done, sq_result, sq_rco_cnt, sq_busy,
        input  sq_cnt_enable, sq_cnt_mode, sq_cnt_D
    );
endinterface

// File: rtl/counter_b4_sched.sv
// rtl/counter_b4_sched.sv - round-robin scheduler sharing one 4-bit counter between two requesters
//
// Ports:
//   sq_clk    rising-edge clock, shared with the counter
//   sq_reset  synchronous active-low reset
//   bus       counter_b4_sched_if.master: job requests in, grant/done/result out,
//             counter enable/mode/D out, counter Q/rco in
//
// Sequence per job: IDLE -> LOAD -> RUN (len cycles, skipped for load-only jobs)
// -> CAPTURE -> DONE -> IDLE.
module counter_b4_sched (
    input  logic                  sq_clk,
    input  logic                  sq_reset,
    counter_b4_sched_if.master    bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_LOAD = 2'b11;

    state_t     state;
    logic       last_gnt;       // requester granted most recently
    logic [1:0] job_mode;
    logic [3:0] job_len;
    logic [3:0] remaining;
    logic [1:0] gnt_q;
    logic [1:0] done_q;
    logic [3:0] result_q;
    logic [3:0] rco_q;
    logic       busy_q;
    logic       en_q;
    logic [1:0] mode_q;
    logic [3:0] d_q;

    logic any_req;
    logic winner;

    // On contention the winner is whichever requester was not granted last.
    always_comb begin
        any_req = |bus.sq_req;
        winner  = bus.sq_req[1] & (~bus.sq_req[0] | ~last_gnt);
    end

    always_ff @(posedge sq_clk) begin
        if (!sq_reset) begin
            state     <= S_IDLE;
            last_gnt  <= 1'b1;      // so requester 0 wins the first contention
            job_mode  <= 2'b00;
            job_len   <= 4'd0;
            remaining <= 4'd0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            result_q  <= 4'd0;
            rco_q     <= 4'd0;
            busy_q    <= 1'b0;
            en_q      <= 1'b0;
            mode_q    <= 2'b00;
            d_q       <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        last_gnt <= winner;
                        gnt_q    <= winner ? 2'b10 : 2'b01;
                        job_mode <= winner ? bus.sq_mode1 : bus.sq_mode0;
                        job_len  <= winner ? bus.sq_len1  : bus.sq_len0;
                        rco_q    <= 4'd0;
                        busy_q   <= 1'b1;
                        en_q     <= 1'b1;
                        mode_q   <= MODE_LOAD;
                        d_q      <= winner ? bus.sq_seed1 : bus.sq_seed0;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    remaining <= job_len;
                    if (job_len == 4'd0 || job_mode == MODE_LOAD) begin
                        mode_q <= MODE_LOAD;
                        state  <= S_CAPTURE;
                    end else begin
                        mode_q <= job_mode;
                        state  <= S_RUN;
                    end
                end

                S_RUN: begin
                    remaining <= remaining - 4'd1;
                    if (bus.sq_cnt_rco && rco_q != 4'hF) begin
                        rco_q <= rco_q + 4'd1;
                    end
                    if (remaining == 4'd1) begin
                        mode_q <= MODE_LOAD;
                        state  <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    result_q <= bus.sq_cnt_Q;
                    done_q   <= gnt_q;
                    en_q     <= 1'b0;
                    mode_q   <= 2'b00;
                    d_q      <= 4'd0;
                    state    <= S_DONE;
                end

                S_DONE: begin
                    done_q <= 2'b00;
                    gnt_q  <= 2'b00;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.sq_gnt        = gnt_q;
        bus.sq_done       = done_q;
        bus.sq_result     = result_q;
        bus.sq_rco_cnt    = rco_q;
        bus.sq_busy       = busy_q;
        bus.sq_cnt_enable = en_q;
        bus.sq_cnt_mode   = mode_q;
        // CAPTURE feeds Q straight back so the reload holds the counter at its
        // final value; a registered copy would be one count behind.
        bus.sq_cnt_D      = (state == S_CAPTURE) ? bus.sq_cnt_Q : d_q;
    end
endmodule
